// File: rtl/flag_unit.sv
// Condition-flag producer: derives {N,Z,C,V} from the execute-stage ALU result and
// holds the architectural flags register plus a one-deep saved copy for exceptions.
module flag_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter logic [3:0]  RESET_NZCV = 4'b0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Valid,
  input  logic             Stall,
  input  logic             CondEx,
  input  logic [1:0]       FlagW,
  input  logic [1:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] Result,
  input  logic             AdderCout,
  input  logic             Save,
  input  logic             Restore,
  output logic [3:0]       Flags,
  output logic [3:0]       FlagsNext,
  output logic [3:0]       SavedFlags,
  output logic             FlagsUpdated
);

  localparam int unsigned MSB = WIDTH - 1;

  // Overflow is only defined for ADD/SUB; logical ops report V=0 but never write it.
  function automatic logic [3:0] derive_nzcv(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] r,
    input logic             cout
  );
    logic n;
    logic z;
    logic v;
    n = r[MSB];
    z = (r == {WIDTH{1'b0}});
    case (op)
      2'b00:   v = (a[MSB] == b[MSB]) & (r[MSB] != a[MSB]);
      2'b01:   v = (a[MSB] != b[MSB]) & (r[MSB] != a[MSB]);
      default: v = 1'b0;
    endcase
    return {n, z, cout, v};
  endfunction

  logic [3:0] alu_nzcv_s;
  logic       wr_nz_s;
  logic       wr_cv_s;
  logic       restore_s;
  logic       save_s;
  logic [3:0] flags_next_s;
  logic [3:0] flags_r;
  logic [3:0] saved_r;
  logic       updated_r;

  // Write qualification and next-state selection (restore beats update)
  always_comb begin
    alu_nzcv_s   = derive_nzcv(ALUControl, SrcA, SrcB, Result, AdderCout);
    wr_nz_s      = Valid & CondEx & FlagW[1] & ~Stall;
    wr_cv_s      = Valid & CondEx & FlagW[0] & ~Stall & ~ALUControl[1];
    restore_s    = Restore & ~Stall;
    save_s       = Save & ~Stall;
    flags_next_s = flags_r;
    if (restore_s) begin
      flags_next_s = saved_r;
    end else begin
      if (wr_nz_s) begin
        flags_next_s[3:2] = alu_nzcv_s[3:2];
      end else begin
        flags_next_s[3:2] = flags_r[3:2];
      end
      if (wr_cv_s) begin
        flags_next_s[1:0] = alu_nzcv_s[1:0];
      end else begin
        flags_next_s[1:0] = flags_r[1:0];
      end
    end
  end

  // Flags, saved copy and commit pulse; Save always captures the pre-update Flags
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r   <= RESET_NZCV;
      saved_r   <= RESET_NZCV;
      updated_r <= 1'b0;
    end else begin
      flags_r <= flags_next_s;
      if (save_s) begin
        saved_r <= flags_r;
      end else begin
        saved_r <= saved_r;
      end
      updated_r <= wr_nz_s | wr_cv_s | restore_s;
    end
  end

  assign Flags        = flags_r;
  assign FlagsNext    = flags_next_s;
  assign SavedFlags   = saved_r;
  assign FlagsUpdated = updated_r;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the flag rules.
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid;
  logic        Stall;
  logic        CondEx;
  logic [1:0]  FlagW;
  logic [1:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [31:0] Result;
  logic        AdderCout;
  logic        Save;
  logic        Restore;
  logic [3:0]  Flags;
  logic [3:0]  FlagsNext;
  logic [3:0]  SavedFlags;
  logic        FlagsUpdated;

  int errors = 0;
  int checks = 0;

  flag_unit #(.WIDTH(32), .RESET_NZCV(4'b0000)) dut (
    .clk(clk), .reset(reset), .Valid(Valid), .Stall(Stall), .CondEx(CondEx),
    .FlagW(FlagW), .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .Result(Result), .AdderCout(AdderCout), .Save(Save), .Restore(Restore),
    .Flags(Flags), .FlagsNext(FlagsNext), .SavedFlags(SavedFlags),
    .FlagsUpdated(FlagsUpdated)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as the ALU: produces Result and carry from the operands arithmetically.
  task automatic set_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    ALUControl = op;
    SrcA = a;
    SrcB = b;
    case (op)
      2'b00: begin sum = {1'b0, a} + {1'b0, b}; Result = sum[31:0]; AdderCout = sum[32]; end
      2'b01: begin Result = a - b; AdderCout = (a >= b); end
      2'b10: begin Result = a & b; AdderCout = 1'($urandom); end
      default: begin Result = a | b; AdderCout = 1'($urandom); end
    endcase
  endtask

  task automatic drive(input logic v, input logic ce, input logic [1:0] fw,
                       input logic sv, input logic rs, input logic st);
    Valid = v; CondEx = ce; FlagW = fw; Save = sv; Restore = rs; Stall = st;
  endtask

  // Reference: flags from the signed/unsigned meaning of the operation.
  function automatic logic [3:0] ref_nzcv();
    longint sa, sb, sr;
    logic v;
    sa = longint'($signed(SrcA));
    sb = longint'($signed(SrcB));
    if (ALUControl == 2'b00) sr = sa + sb;
    else sr = sa - sb;
    v = (ALUControl[1] == 1'b0) && (sr > 64'sd2147483647 || sr < -64'sd2147483648);
    return {Result[31], Result == 32'd0, AdderCout, v};
  endfunction

  logic [3:0] m_flags = 4'b0000;
  logic [3:0] m_saved = 4'b0000;
  logic       m_upd   = 1'b0;

  function automatic logic [3:0] ref_next();
    logic [3:0] f;
    logic [3:0] d;
    f = m_flags;
    d = ref_nzcv();
    if (Stall) return f;
    if (Restore) return m_saved;
    if (Valid && CondEx && FlagW[1]) f[3:2] = d[3:2];
    if (Valid && CondEx && FlagW[0] && (ALUControl == 2'b00 || ALUControl == 2'b01)) f[1:0] = d[1:0];
    return f;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    set_alu(2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
    tick();
    tick();
    checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
    checks++; if (SavedFlags !== 4'b0000) begin errors++; $display("FAIL reset_saved got=%b exp=0000", SavedFlags); end
    checks++; if (FlagsUpdated !== 1'b0) begin errors++; $display("FAIL reset_upd got=%b exp=0", FlagsUpdated); end
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_add_overflow();
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    set_alu(2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
    #1;
    checks++; if (FlagsNext !== 4'b1001) begin errors++; $display("FAIL add_next got=%b exp=1001", FlagsNext); end
    tick();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    checks++; if (Flags !== 4'b1001) begin errors++; $display("FAIL add_flags got=%b exp=1001", Flags); end
    checks++; if (FlagsUpdated !== 1'b1) begin errors++; $display("FAIL add_upd got=%b exp=1", FlagsUpdated); end
    tick();
    checks++; if (FlagsUpdated !== 1'b0) begin errors++; $display("FAIL add_upd_pulse got=%b exp=0", FlagsUpdated); end
  endtask

  task automatic test_sub_zero();
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    set_alu(2'b01, 32'd5, 32'd5);
    tick();
    checks++; if (Flags !== 4'b0110) begin errors++; $display("FAIL sub_flags got=%b exp=0110", Flags); end
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    set_alu(2'b00, 32'h8000_0000, 32'h8000_0001);
    tick();
    checks++; if (Flags !== 4'b0110) begin errors++; $display("FAIL condex_hold got=%b exp=0110", Flags); end
    checks++; if (FlagsUpdated !== 1'b0) begin errors++; $display("FAIL condex_upd got=%b exp=0", FlagsUpdated); end
  endtask

  task automatic test_logical();
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    set_alu(2'b00, 32'h8000_0000, 32'h8000_0001);
    tick();
    checks++; if (Flags !== 4'b0011) begin errors++; $display("FAIL setup_0011 got=%b exp=0011", Flags); end
    set_alu(2'b10, 32'h0000_00F0, 32'h0000_000F);
    AdderCout = 1'b0;
    tick();
    checks++; if (Flags !== 4'b0111) begin errors++; $display("FAIL and_keep_cv got=%b exp=0111", Flags); end
  endtask

  task automatic test_save_restore();
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    set_alu(2'b00, 32'h8000_0000, 32'h0000_0000);
    tick();
    checks++; if (Flags !== 4'b1000) begin errors++; $display("FAIL setup_1000 got=%b exp=1000", Flags); end
    drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    set_alu(2'b00, 32'h0000_0000, 32'h0000_0000);
    tick();
    checks++; if (SavedFlags !== 4'b1000) begin errors++; $display("FAIL save_pre got=%b exp=1000", SavedFlags); end
    checks++; if (Flags !== 4'b0100) begin errors++; $display("FAIL save_upd got=%b exp=0100", Flags); end
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
    set_alu(2'b00, 32'h7FFF_FFFF, 32'h0000_0001);
    tick();
    checks++; if (Flags !== 4'b1000) begin errors++; $display("FAIL restore_wins got=%b exp=1000", Flags); end
    checks++; if (FlagsUpdated !== 1'b1) begin errors++; $display("FAIL restore_upd got=%b exp=1", FlagsUpdated); end
  endtask

  task automatic test_stall_swap();
    // Build Flags=1010 and save it, then Flags=0001 via separate C,V and N,Z writes.
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    set_alu(2'b00, 32'hC000_0000, 32'hC000_0000);
    tick();
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    set_alu(2'b00, 32'h4000_0000, 32'h4000_0000);
    tick();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    set_alu(2'b00, 32'h0000_0001, 32'h0000_0000);
    tick();
    checks++; if ({Flags, SavedFlags} !== 8'b0001_1010) begin errors++; $display("FAIL setup_swap got=%b_%b exp=0001_1010", Flags, SavedFlags); end
    drive(1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    set_alu(2'b00, 32'h0000_0000, 32'h0000_0000);
    #1;
    checks++; if (FlagsNext !== 4'b0001) begin errors++; $display("FAIL stall_next got=%b exp=0001", FlagsNext); end
    tick();
    checks++; if ({Flags, SavedFlags} !== 8'b0001_1010) begin errors++; $display("FAIL stall_hold got=%b_%b exp=0001_1010", Flags, SavedFlags); end
    checks++; if (FlagsUpdated !== 1'b0) begin errors++; $display("FAIL stall_upd got=%b exp=0", FlagsUpdated); end
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    tick();
    checks++; if ({Flags, SavedFlags} !== 8'b1010_0001) begin errors++; $display("FAIL swap got=%b_%b exp=1010_0001", Flags, SavedFlags); end
    checks++; if (FlagsUpdated !== 1'b1) begin errors++; $display("FAIL swap_upd got=%b exp=1", FlagsUpdated); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_random();
    logic [3:0] exp_next;
    logic [31:0] a, b;
    m_flags = Flags;
    m_saved = SavedFlags;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = 32'h7FFF_FFFF; b = $urandom_range(0, 2); end
        1: begin a = $urandom; b = a; end
        2: begin a = 32'h8000_0000; b = $urandom_range(0, 2); end
        default: begin a = $urandom; b = $urandom; end
      endcase
      set_alu(2'($urandom), a, b);
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), 2'($urandom),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
      reset = ($urandom_range(0, 29) == 0);
      #1;
      exp_next = ref_next();
      checks++; if (FlagsNext !== exp_next) begin errors++; $display("FAIL rnd_next i=%0d got=%b exp=%b", i, FlagsNext, exp_next); end
      if (reset) begin
        m_flags = 4'b0000; m_saved = 4'b0000; m_upd = 1'b0;
      end else begin
        m_upd = (exp_next != m_flags) || (!Stall && (Restore ||
                (Valid && CondEx && (FlagW[1] || (FlagW[0] && !ALUControl[1])))));
        if (!Stall && Save) m_saved = m_flags;
        m_flags = exp_next;
      end
      tick();
      checks++; if (Flags !== m_flags) begin errors++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, Flags, m_flags); end
      checks++; if (SavedFlags !== m_saved) begin errors++; $display("FAIL rnd_saved i=%0d got=%b exp=%b", i, SavedFlags, m_saved); end
      checks++; if (FlagsUpdated !== m_upd) begin errors++; $display("FAIL rnd_upd i=%0d got=%b exp=%b", i, FlagsUpdated, m_upd); end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    set_alu(2'b00, 32'd0, 32'd0);
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_logical();
    test_save_restore();
    test_stall_swap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
